// File: rtl/uart_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_fifo_pkg : shared state encodings and bit-timing helper for uart_fifo
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_fifo_pkg;

   localparam int BitCountWidth = 3;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE        = 3'd0,
      RX_START_CHECK = 3'd1,
      RX_DATA        = 3'd2,
      RX_PARITY      = 3'd3,
      RX_STOP        = 3'd4
   } rx_state_t;

   function automatic int clocks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : show-ahead synchronous FIFO with registered count/full/empty
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
   parameter int DataBitWidth  = 8,
   parameter int DepthBitWidth = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DataBitWidth-1:0] i_wr_data,
   input  logic                    i_push,
   input  logic                    i_pop,
   output logic [DataBitWidth-1:0] o_rd_data,
   output logic [DepthBitWidth:0]  o_count,
   output logic                    o_full,
   output logic                    o_empty
);

   localparam int c_DEPTH = 1 << DepthBitWidth;
   localparam logic [DepthBitWidth:0] c_ALMOST_FULL = (DepthBitWidth+1)'(c_DEPTH - 1);
   localparam logic [DepthBitWidth:0] c_ONE         = (DepthBitWidth+1)'(1);

   logic [DataBitWidth-1:0]  r_mem [c_DEPTH];
   logic [DepthBitWidth-1:0] r_wr_ptr;
   logic [DepthBitWidth-1:0] r_rd_ptr;
   logic [DepthBitWidth:0]   r_count;
   logic                     r_full;
   logic                     r_empty;
   logic                     w_push;
   logic                     w_pop;

   // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle
   assign w_pop  = i_pop && !r_empty;
   assign w_push = i_push && (!r_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10: begin
               r_count <= r_count + 1'b1;
               r_full  <= (r_count == c_ALMOST_FULL);
               r_empty <= 1'b0;
            end
            2'b01: begin
               r_count <= r_count - 1'b1;
               r_full  <= 1'b0;
               r_empty <= (r_count == c_ONE);
            end
            default: ;
         endcase
      end
   end

   assign o_rd_data = r_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign o_full    = r_full;
   assign o_empty   = r_empty;

endmodule

`default_nettype wire

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo : FIFO-buffered full-duplex UART, 8N1 (8E1 with UART_FIFO_PARITY_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_fifo
   import uart_fifo_pkg::*;
#(
   parameter int ClockFrequencyHz    = 20_250_000,
   parameter int BaudRate            = 115_200,
   parameter int TxFifoDepthBitWidth = 4,
   parameter int RxFifoDepthBitWidth = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   tx_data,
   input  logic                         tx_write,
   output logic                         tx_full,
   output logic [TxFifoDepthBitWidth:0] tx_count,
   output logic                         tx_idle,
   output logic [7:0]                   rx_data,
   input  logic                         rx_read,
   output logic                         rx_empty,
   output logic [RxFifoDepthBitWidth:0] rx_count,
   output logic                         rx_overrun,
   output logic                         rx_frame_error,
   output logic                         rx_parity_error,
   input  logic                         err_clear,
   output logic                         uart_tx,
   input  logic                         uart_rx
);

   localparam int c_CPB   = clocks_per_bit(ClockFrequencyHz, BaudRate);
   localparam int c_CNT_W = $clog2(c_CPB);
   localparam logic [c_CNT_W-1:0]       c_CNT_LAST = c_CNT_W'(c_CPB - 1);
   localparam logic [c_CNT_W-1:0]       c_CNT_HALF = c_CNT_W'(c_CPB / 2 - 1);
   localparam logic [BitCountWidth-1:0] c_BIT_LAST = BitCountWidth'(7);
`ifdef UART_FIFO_PARITY_EN
   localparam bit c_PARITY_EN = 1'b1;
`else
   localparam bit c_PARITY_EN = 1'b0;
`endif

   if (c_CPB < 4) begin : g_cpb_check
      $error("uart_fifo: ClocksPerBit must be at least 4");
   end

   // ---------------- transmit ----------------
   tx_state_t                r_tx_state, w_tx_state_next;
   logic [c_CNT_W-1:0]       r_tx_cnt;
   logic [BitCountWidth-1:0] r_tx_bit;
   logic [7:0]               r_tx_shift, w_tx_shift_next, w_tx_head;
   logic                     r_tx_parity, r_uart_tx;
   logic                     w_tx_line, w_tx_done, w_tx_pop, w_tx_empty;

   sync_fifo #(.DataBitWidth(8), .DepthBitWidth(TxFifoDepthBitWidth)) u_tx_fifo (
      .clk(clk), .rst(rst), .i_wr_data(tx_data), .i_push(tx_write), .i_pop(w_tx_pop),
      .o_rd_data(w_tx_head), .o_count(tx_count), .o_full(tx_full), .o_empty(w_tx_empty)
   );

   assign w_tx_done = (r_tx_cnt == c_CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state  <= TX_IDLE;
         r_tx_cnt    <= '0;
         r_tx_bit    <= '0;
         r_tx_shift  <= '0;
         r_tx_parity <= 1'b0;
         r_uart_tx   <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_next;
         r_tx_cnt   <= (r_tx_state == TX_IDLE || w_tx_state_next != r_tx_state || w_tx_done)
                       ? '0 : r_tx_cnt + 1'b1;
         if (r_tx_state != TX_DATA)  r_tx_bit <= '0;
         else if (w_tx_done)         r_tx_bit <= r_tx_bit + 1'b1;
         r_tx_shift <= w_tx_shift_next;
         if (w_tx_pop) r_tx_parity <= ^w_tx_head;
         r_uart_tx  <= w_tx_line;
      end
   end

   always_comb begin
      w_tx_state_next = r_tx_state;
      case (r_tx_state)
         TX_IDLE:   if (!w_tx_empty) w_tx_state_next = TX_START;
         TX_START:  if (w_tx_done) w_tx_state_next = TX_DATA;
         TX_DATA:   if (w_tx_done && r_tx_bit == c_BIT_LAST)
                       w_tx_state_next = c_PARITY_EN ? TX_PARITY : TX_STOP;
         TX_PARITY: if (w_tx_done) w_tx_state_next = TX_STOP;
         TX_STOP:   if (w_tx_done) w_tx_state_next = w_tx_empty ? TX_IDLE : TX_START;
         default:   w_tx_state_next = TX_IDLE;
      endcase
   end

   // Line level is computed for the upcoming state so uart_tx comes straight from a flop
   always_comb begin
      w_tx_pop        = 1'b0;
      w_tx_shift_next = r_tx_shift;
      w_tx_line       = 1'b1;
      if (r_tx_state == TX_IDLE || (r_tx_state == TX_STOP && w_tx_done))
         w_tx_pop = !w_tx_empty;
      if (w_tx_pop)
         w_tx_shift_next = w_tx_head;
      else if (r_tx_state == TX_DATA && w_tx_done)
         w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
      case (w_tx_state_next)
         TX_START:  w_tx_line = 1'b0;
         TX_DATA:   w_tx_line = w_tx_shift_next[0];
         TX_PARITY: w_tx_line = r_tx_parity;
         default:   w_tx_line = 1'b1;
      endcase
   end

   assign uart_tx = r_uart_tx;
   assign tx_idle = (r_tx_state == TX_IDLE) && w_tx_empty;

   // ---------------- receive ----------------
   rx_state_t                r_rx_state, w_rx_state_next;
   logic [1:0]               r_rx_sync;
   logic [c_CNT_W-1:0]       r_rx_cnt;
   logic [BitCountWidth-1:0] r_rx_bit;
   logic [7:0]               r_rx_shift;
   logic                     r_rx_par_bit, r_rx_overrun, r_rx_frame_error;
   logic                     w_rx, w_rx_sample, w_rx_stop, w_rx_full;
   logic                     w_rx_push, w_rx_frame_err, w_rx_par_err, w_rx_ovr;

   sync_fifo #(.DataBitWidth(8), .DepthBitWidth(RxFifoDepthBitWidth)) u_rx_fifo (
      .clk(clk), .rst(rst), .i_wr_data(r_rx_shift), .i_push(w_rx_push), .i_pop(rx_read),
      .o_rd_data(rx_data), .o_count(rx_count), .o_full(w_rx_full), .o_empty(rx_empty)
   );

   assign w_rx = r_rx_sync[1];
   assign w_rx_sample = (r_rx_state == RX_START_CHECK) ? (r_rx_cnt == c_CNT_HALF) :
                        (r_rx_state == RX_IDLE)        ? 1'b0 : (r_rx_cnt == c_CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_sync        <= 2'b11;
         r_rx_state       <= RX_IDLE;
         r_rx_cnt         <= '0;
         r_rx_bit         <= '0;
         r_rx_shift       <= '0;
         r_rx_par_bit     <= 1'b0;
         r_rx_overrun     <= 1'b0;
         r_rx_frame_error <= 1'b0;
      end else begin
         r_rx_sync  <= {r_rx_sync[0], uart_rx};
         r_rx_state <= w_rx_state_next;
         r_rx_cnt   <= (r_rx_state == RX_IDLE || w_rx_state_next != r_rx_state || w_rx_sample)
                       ? '0 : r_rx_cnt + 1'b1;
         if (r_rx_state != RX_DATA)  r_rx_bit <= '0;
         else if (w_rx_sample)       r_rx_bit <= r_rx_bit + 1'b1;
         if (r_rx_state == RX_DATA && w_rx_sample)   r_rx_shift   <= {w_rx, r_rx_shift[7:1]};
         if (r_rx_state == RX_PARITY && w_rx_sample) r_rx_par_bit <= w_rx;
         if (err_clear)            r_rx_overrun <= 1'b0;
         else if (w_rx_ovr)        r_rx_overrun <= 1'b1;
         if (err_clear)            r_rx_frame_error <= 1'b0;
         else if (w_rx_frame_err)  r_rx_frame_error <= 1'b1;
      end
   end

   always_comb begin
      w_rx_state_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:        if (!w_rx) w_rx_state_next = RX_START_CHECK;
         RX_START_CHECK: if (w_rx_sample) w_rx_state_next = w_rx ? RX_IDLE : RX_DATA;
         RX_DATA:        if (w_rx_sample && r_rx_bit == c_BIT_LAST)
                            w_rx_state_next = c_PARITY_EN ? RX_PARITY : RX_STOP;
         RX_PARITY:      if (w_rx_sample) w_rx_state_next = RX_STOP;
         RX_STOP:        if (w_rx_sample) w_rx_state_next = RX_IDLE;
         default:        w_rx_state_next = RX_IDLE;
      endcase
   end

   always_comb begin
      w_rx_stop      = (r_rx_state == RX_STOP) && w_rx_sample;
      w_rx_frame_err = w_rx_stop && !w_rx;
      w_rx_par_err   = w_rx_stop && w_rx && c_PARITY_EN && (r_rx_par_bit != ^r_rx_shift);
      w_rx_push      = w_rx_stop && w_rx && !w_rx_par_err;
      w_rx_ovr       = w_rx_push && w_rx_full && !rx_read;
   end

   assign rx_overrun     = r_rx_overrun;
   assign rx_frame_error = r_rx_frame_error;

`ifdef UART_FIFO_PARITY_EN
   logic r_rx_parity_error;
   always_ff @(posedge clk) begin
      if (rst || err_clear) r_rx_parity_error <= 1'b0;
      else if (w_rx_par_err) r_rx_parity_error <= 1'b1;
   end
   assign rx_parity_error = r_rx_parity_error;
`else
   assign rx_parity_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo : directed self-checking bench for uart_fifo (10 clocks/bit)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_fifo;

`ifdef UART_FIFO_PARITY_EN
   localparam int c_FRAME_BITS = 11;
`else
   localparam int c_FRAME_BITS = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_write = 1'b0;
   logic       tx_full;
   logic [2:0] tx_count;
   logic       tx_idle;
   logic [7:0] rx_data;
   logic       rx_read = 1'b0;
   logic       rx_empty;
   logic [2:0] rx_count;
   logic       rx_overrun, rx_frame_error, rx_parity_error;
   logic       err_clear = 1'b0;
   logic       uart_tx;
   logic       uart_rx = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_fifo #(
      .ClockFrequencyHz(20_250_000), .BaudRate(2_025_000),
      .TxFifoDepthBitWidth(2), .RxFifoDepthBitWidth(2)
   ) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
      .tx_count(tx_count), .tx_idle(tx_idle), .rx_data(rx_data), .rx_read(rx_read),
      .rx_empty(rx_empty), .rx_count(rx_count), .rx_overrun(rx_overrun),
      .rx_frame_error(rx_frame_error), .rx_parity_error(rx_parity_error),
      .err_clear(err_clear), .uart_tx(uart_tx), .uart_rx(uart_rx)
   );

   function automatic logic frame_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (c_FRAME_BITS == 11 && k == 9) return ^d;
      return 1'b1;
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic stop);
      for (int k = 0; k < c_FRAME_BITS; k++) begin
         uart_rx = (k == c_FRAME_BITS - 1) ? stop : frame_bit(d, k);
         repeat (10) @(negedge clk);
      end
      uart_rx = 1'b1;
   endtask

   task automatic pulse_err_clear();
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset uart_tx: got %b expected 1", uart_tx); end
      checks++; if (tx_count !== 3'd0) begin errors++; $display("FAIL reset tx_count: got %0d expected 0", tx_count); end
      checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset tx_full: got %b expected 0", tx_full); end
      checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL reset tx_idle: got %b expected 1", tx_idle); end
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset rx_empty: got %b expected 1", rx_empty); end
      checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL reset rx_count: got %0d expected 0", rx_count); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset rx_data: got %h expected 00", rx_data); end
      checks++; if ({rx_overrun, rx_frame_error, rx_parity_error} !== 3'b000) begin
         errors++; $display("FAIL reset errors: got %b expected 000", {rx_overrun, rx_frame_error, rx_parity_error});
      end
   endtask

   task automatic test_tx_single();
      logic exp;
      @(negedge clk);
      tx_data  = 8'hAA;
      tx_write = 1'b1;
      @(negedge clk);           // E0 has applied the push
      tx_write = 1'b0;
      @(negedge clk);           // E1: start bit on the line
      for (int b = 0; b < c_FRAME_BITS; b++) begin
         exp = frame_bit(8'hAA, b);
         for (int c = 0; c < 10; c++) begin
            if (c == 0 || c == 9) begin
               checks++;
               if (uart_tx !== exp) begin
                  errors++; $display("FAIL tx_single bit %0d cycle %0d: got %b expected %b", b, c, uart_tx, exp);
               end
            end
            if (b == c_FRAME_BITS - 1 && c == 9) begin
               checks++; if (tx_idle !== 1'b0) begin errors++; $display("FAIL tx_single idle early: got %b expected 0", tx_idle); end
            end
            @(negedge clk);
         end
      end
      checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL tx_single idle end: got %b expected 1", tx_idle); end
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_single line end: got %b expected 1", uart_tx); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got;
      logic [7:0] exp;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) begin
            checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL burst tx_full: got %b expected 1", tx_full); end
            checks++; if (tx_count !== 3'd4) begin errors++; $display("FAIL burst tx_count: got %0d expected 4", tx_count); end
         end
         tx_data  = 8'(8'h11 * (i + 1));
         tx_write = 1'b1;
      end
      @(negedge clk);           // now E1+4 of the first frame
      tx_write = 1'b0;
      checks++; if (tx_count !== 3'd4) begin errors++; $display("FAIL burst drop count: got %0d expected 4", tx_count); end
      @(negedge clk);           // mid bit 0 of frame 0
      for (int f = 0; f < 5; f++) begin
         got = 8'h00;
         exp = 8'(8'h11 * (f + 1));
         for (int k = 0; k < c_FRAME_BITS; k++) begin
            if (k == 0) begin
               checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL burst frame %0d start: got %b expected 0", f, uart_tx); end
            end else if (k <= 8) begin
               got[k-1] = uart_tx;
            end else if (k == c_FRAME_BITS - 1) begin
               checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL burst frame %0d stop: got %b expected 1", f, uart_tx); end
            end
            repeat (10) @(negedge clk);
         end
         checks++; if (got !== exp) begin errors++; $display("FAIL burst frame %0d data: got %h expected %h", f, got, exp); end
      end
      checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL burst idle end: got %b expected 1", tx_idle); end
      checks++; if (tx_count !== 3'd0) begin errors++; $display("FAIL burst count end: got %0d expected 0", tx_count); end
   endtask

   task automatic test_rx_single();
      @(negedge clk);
      send_frame(8'h55, 1'b1);
      repeat (3) @(negedge clk);
      checks++; if (rx_count !== 3'd1) begin errors++; $display("FAIL rx_single count: got %0d expected 1", rx_count); end
      checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL rx_single data: got %h expected 55", rx_data); end
      rx_read = 1'b1;
      @(negedge clk);
      rx_read = 1'b0;
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rx_single empty: got %b expected 1", rx_empty); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rx_single data after pop: got %h expected 00", rx_data); end
   endtask

   task automatic test_rx_overrun();
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      repeat (3) @(negedge clk);
      checks++; if (rx_count !== 3'd4) begin errors++; $display("FAIL overrun count: got %0d expected 4", rx_count); end
      checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL overrun flag: got %b expected 1", rx_overrun); end
      for (int i = 1; i <= 4; i++) begin
         checks++; if (rx_data !== 8'(i)) begin errors++; $display("FAIL overrun pop %0d: got %h expected %h", i, rx_data, 8'(i)); end
         rx_read = 1'b1;
         @(negedge clk);
         rx_read = 1'b0;
      end
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL overrun drained: got %b expected 1", rx_empty); end
      pulse_err_clear();
      checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL overrun clear: got %b expected 0", rx_overrun); end
   endtask

   task automatic test_rx_errors();
      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (30) @(negedge clk);
      checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL glitch count: got %0d expected 0", rx_count); end
      checks++; if ({rx_overrun, rx_frame_error, rx_parity_error} !== 3'b000) begin
         errors++; $display("FAIL glitch errors: got %b expected 000", {rx_overrun, rx_frame_error, rx_parity_error});
      end
      send_frame(8'h3C, 1'b0);
      repeat (20) @(negedge clk);
      checks++; if (rx_frame_error !== 1'b1) begin errors++; $display("FAIL frame_error flag: got %b expected 1", rx_frame_error); end
      checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL frame_error count: got %0d expected 0", rx_count); end
      pulse_err_clear();
      checks++; if (rx_frame_error !== 1'b0) begin errors++; $display("FAIL frame_error clear: got %b expected 0", rx_frame_error); end
   endtask

   task automatic test_reset_midframe();
      @(negedge clk);
      tx_data  = 8'h0F;
      tx_write = 1'b1;
      @(negedge clk);
      tx_data  = 8'hF0;
      @(negedge clk);
      tx_write = 1'b0;
      repeat (15) @(negedge clk);
      checks++; if (tx_idle !== 1'b0) begin errors++; $display("FAIL midframe busy: got %b expected 0", tx_idle); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midframe line: got %b expected 1", uart_tx); end
      checks++; if (tx_count !== 3'd0) begin errors++; $display("FAIL midframe count: got %0d expected 0", tx_count); end
      repeat (20) @(negedge clk);
      checks++; if (tx_idle !== 1'b1 || uart_tx !== 1'b1) begin
         errors++; $display("FAIL midframe stays idle: got idle=%b line=%b expected 1/1", tx_idle, uart_tx);
      end
   endtask

   initial begin
      test_reset();
      test_tx_single();
      test_back_to_back();
      test_rx_single();
      test_rx_overrun();
      test_rx_errors();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
